// File: rtl/line_plotter.sv
// line_plotter: integrates draw_line direction codes into an absolute pen
// position and queues every visited pixel in a small FIFO that a framebuffer
// writer drains through a valid/ready handshake.
module line_plotter #(
    parameter int COORD_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [COORD_W-1:0] start_x,
    input  logic [COORD_W-1:0] start_y,
    input  logic               step_valid,
    input  logic [1:0]         step_dirx,
    input  logic [1:0]         step_diry,
    output logic               step_ready,
    input  logic               line_done,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    input  logic               pix_ready,
    output logic               busy,
    output logic               plot_done,
    output logic               err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_r;
    logic [COORD_W-1:0] pen_x_r;
    logic [COORD_W-1:0] pen_y_r;
    logic [COORD_W-1:0] mem_x_r [FIFO_DEPTH];
    logic [COORD_W-1:0] mem_y_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               plot_done_r;
    logic               err_r;

    logic               step_ready_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               illegal_s;
    logic [COORD_W-1:0] next_x_s;
    logic [COORD_W-1:0] next_y_s;

    // One axis move: 01 -> +1, 10 -> -1, 00/11 -> hold (modulo arithmetic).
    function automatic logic [COORD_W-1:0] apply_dir(input logic [COORD_W-1:0] c,
                                                     input logic [1:0]         d);
        logic [COORD_W-1:0] r;
        case (d)
            2'b01:   r = c + COORD_W'(1);
            2'b10:   r = c - COORD_W'(1);
            default: r = c;
        endcase
        return r;
    endfunction

    // An axis actually moves only for the two legal non-hold codes.
    function automatic logic dir_moves(input logic [1:0] d);
        return (d == 2'b01) || (d == 2'b10);
    endfunction

    // Handshake decode and next pen position; load pre-empts any step or pop.
    always_comb begin
        step_ready_s = 1'b0;
        accept_s     = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        illegal_s    = 1'b0;
        next_x_s     = apply_dir(pen_x_r, step_dirx);
        next_y_s     = apply_dir(pen_y_r, step_diry);
        if ((state_r == ST_RUN) && (count_r < CNT_W'(FIFO_DEPTH))) begin
            step_ready_s = 1'b1;
        end else begin
            step_ready_s = 1'b0;
        end
        if (!load) begin
            accept_s  = step_valid && step_ready_s;
            push_s    = accept_s && (dir_moves(step_dirx) || dir_moves(step_diry));
            pop_s     = (count_r != {CNT_W{1'b0}}) && pix_ready;
            illegal_s = accept_s && ((step_dirx == 2'b11) || (step_diry == 2'b11));
        end else begin
            accept_s  = 1'b0;
            push_s    = 1'b0;
            pop_s     = 1'b0;
            illegal_s = 1'b0;
        end
    end

    // Line-level FSM plus pen, sticky error and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pen_x_r     <= {COORD_W{1'b0}};
            pen_y_r     <= {COORD_W{1'b0}};
            plot_done_r <= 1'b0;
            err_r       <= 1'b0;
        end else if (load) begin
            state_r     <= ST_RUN;
            pen_x_r     <= start_x;
            pen_y_r     <= start_y;
            plot_done_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            plot_done_r <= 1'b0;
            if (accept_s) begin
                pen_x_r <= next_x_s;
                pen_y_r <= next_y_s;
            end
            if (illegal_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (line_done) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r     <= ST_IDLE;
                        plot_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage: load writes the start pixel into slot 0 of a flushed queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_x_r[i] <= {COORD_W{1'b0}};
                mem_y_r[i] <= {COORD_W{1'b0}};
            end
        end else if (load) begin
            mem_x_r[0] <= start_x;
            mem_y_r[0] <= start_y;
        end else if (push_s) begin
            mem_x_r[wr_ptr_r] <= next_x_s;
            mem_y_r[wr_ptr_r] <= next_y_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (load) begin
            wr_ptr_r <= PTR_W'(1);
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_W'(1);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign step_ready = step_ready_s;
    assign pix_valid  = (count_r != {CNT_W{1'b0}});
    assign pix_x      = mem_x_r[rd_ptr_r];
    assign pix_y      = mem_y_r[rd_ptr_r];
    assign busy       = (state_r != ST_IDLE);
    assign plot_done  = plot_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_line_plotter.sv
// Directed bench for line_plotter: hand-listed expected pixel sequences are
// checked on every pop, plus handshake, status and reset behaviour.
module tb_line_plotter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] start_x;
    logic [7:0] start_y;
    logic       step_valid;
    logic [1:0] step_dirx;
    logic [1:0] step_diry;
    logic       step_ready;
    logic       line_done;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_ready;
    logic       busy;
    logic       plot_done;
    logic       err;

    int vec_cnt = 0;
    int miss_cnt = 0;
    logic [15:0] exp_q[$];

    line_plotter #(.COORD_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .start_x(start_x), .start_y(start_y),
        .step_valid(step_valid), .step_dirx(step_dirx), .step_diry(step_diry),
        .step_ready(step_ready), .line_done(line_done), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_ready(pix_ready), .busy(busy),
        .plot_done(plot_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic exp_push(input int x, input int y);
        exp_q.push_back({x[7:0], y[7:0]});
    endtask

    // Check the head against the scoreboard if it pops at the coming edge,
    // then advance one clock and settle.
    task automatic tick();
        logic [15:0] e;
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {pix_x, pix_y}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pop_x", pix_x, e[15:8]);
                chk("pop_y", pix_y, e[7:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int x, input int y);
        load    = 1'b1;
        start_x = x[7:0];
        start_y = y[7:0];
        tick();
        load    = 1'b0;
    endtask

    task automatic finish_line();
        logic seen;
        seen       = 1'b0;
        step_valid = 1'b0;
        pix_ready  = 1'b1;
        line_done  = 1'b1;
        tick();
        line_done  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                tick();
                seen = plot_done;
            end
        end
        chk("plot_done_seen", seen, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; start_x = 8'd0; start_y = 8'd0;
        step_valid = 1'b0; step_dirx = 2'b00; step_diry = 2'b00;
        line_done = 1'b0; pix_ready = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_step_ready", step_ready, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_plot_done", plot_done, 0);
        chk("rst_err", err, 0);
        step_valid = 1'b1; step_dirx = 2'b01; step_diry = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_step_ready", step_ready, 0);
            chk("idle_pix_valid", pix_valid, 0);
        end
        step_valid = 1'b0;

        // Diagonal then vertical line, consumer always ready
        pix_ready = 1'b1;
        exp_push(30, 30); exp_push(29, 29); exp_push(28, 28); exp_push(27, 27);
        exp_push(26, 26); exp_push(25, 25); exp_push(24, 24); exp_push(24, 23);
        exp_push(24, 22); exp_push(24, 21);
        do_load(30, 30);
        chk("load_pix_valid", pix_valid, 1);
        chk("load_pix_x", pix_x, 30);
        chk("load_pix_y", pix_y, 30);
        chk("load_step_ready", step_ready, 1);
        chk("load_busy", busy, 1);
        step_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step_dirx = (i < 6) ? 2'b10 : 2'b00;
            step_diry = 2'b10;
            chk("thru_step_ready", step_ready, 1);
            tick();
        end
        step_valid = 1'b0;
        line_done  = 1'b1;
        tick();
        line_done  = 1'b0;
        chk("drain_pix_valid", pix_valid, 0);
        chk("drain_busy", busy, 1);
        chk("drain_plot_done", plot_done, 0);
        tick();
        chk("done_pulse", plot_done, 1);
        chk("done_busy", busy, 0);
        tick();
        chk("done_cleared", plot_done, 0);
        chk("line1_drained", exp_q.size(), 0);

        // Backpressure with a 4-entry FIFO
        pix_ready = 1'b0;
        exp_push(20, 25); exp_push(21, 26); exp_push(22, 27);
        exp_push(23, 28); exp_push(24, 29); exp_push(25, 30);
        do_load(20, 25);
        step_valid = 1'b1; step_dirx = 2'b01; step_diry = 2'b01;
        chk("bp_ready0", step_ready, 1);
        tick();
        chk("bp_ready1", step_ready, 1);
        tick();
        chk("bp_ready2", step_ready, 1);
        tick();
        chk("bp_full_ready", step_ready, 0);
        tick();
        chk("bp_still_full", step_ready, 0);
        chk("bp_head_x", pix_x, 20);
        chk("bp_head_y", pix_y, 25);
        pix_ready = 1'b1;
        repeat (3) tick();
        finish_line();

        // Wrap-around and hold step
        pix_ready = 1'b0;
        exp_push(255, 0); exp_push(0, 255);
        do_load(255, 0);
        step_valid = 1'b1; step_dirx = 2'b01; step_diry = 2'b10;
        tick();
        step_dirx = 2'b00; step_diry = 2'b00;
        chk("hold_step_ready", step_ready, 1);
        tick();
        step_valid = 1'b0;
        pix_ready  = 1'b1;
        tick();
        tick();
        chk("wrap_only_two", pix_valid, 0);
        finish_line();

        // Illegal code then reload mid-line
        pix_ready = 1'b0;
        exp_push(5, 5); exp_push(5, 6);
        do_load(5, 5);
        step_valid = 1'b1; step_dirx = 2'b11; step_diry = 2'b01;
        tick();
        step_valid = 1'b0;
        chk("illegal_err", err, 1);
        pix_ready = 1'b1;
        tick();
        tick();
        chk("illegal_one_pixel", pix_valid, 0);
        chk("err_sticky", err, 1);
        pix_ready = 1'b0;
        step_valid = 1'b1; step_dirx = 2'b01; step_diry = 2'b00;
        tick();
        step_valid = 1'b0;
        chk("preload_pending", pix_valid, 1);
        exp_push(40, 40);
        do_load(40, 40);
        chk("reload_err", err, 0);
        chk("reload_valid", pix_valid, 1);
        chk("reload_x", pix_x, 40);
        chk("reload_y", pix_y, 40);
        pix_ready = 1'b1;
        tick();
        chk("reload_flushed", pix_valid, 0);
        finish_line();

        // Asynchronous reset during DRAIN with three queued pixels
        pix_ready = 1'b0;
        do_load(1, 1);
        step_valid = 1'b1; step_dirx = 2'b01; step_diry = 2'b00;
        tick();
        tick();
        step_valid = 1'b0;
        line_done  = 1'b1;
        tick();
        line_done  = 1'b0;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_valid", pix_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", pix_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", plot_done, 0);
        tick();
        chk("rst_hold_done", plot_done, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", plot_done, 0);
        chk("post_rst_ready", step_ready, 0);
        chk("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/line_plotter.md
# line_plotter

Step-stream consumer for `draw_line`. It takes the per-cycle direction codes `dirx`/`diry` that `draw_line` emits and integrates them into an absolute pen position. It writes every visited pixel into a small output FIFO, which a framebuffer writer drains through a valid/ready handshake. It sits between `draw_line` and the VGA frame-memory write port. It converts relative motion back into coordinates and reports when a whole line has been committed to memory.

## Interface
Parameters:
- `COORD_W`, default 8: width of the x/y coordinates. Matches the `draw_line` endpoints.
- `FIFO_DEPTH`, default 4: number of pixel entries in the output FIFO. Must be a power of two, 2 or more.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `load`  in  1: one-cycle pulse; latches `start_x`/`start_y` as the pen position and begins a line.
- `start_x`, `start_y`  in  COORD_W each: first pixel of the line.
- `step_valid`  in  1: `step_dirx`/`step_diry` hold a step.
- `step_dirx`, `step_diry`  in  2 each: direction code per axis. 00 = hold, 01 = +1, 10 = −1, 11 = illegal.
- `step_ready`  out  1: block can accept a step this cycle.
- `line_done`  in  1: `done` from `draw_line`; no further steps for this line.
- `pix_valid`  out  1: FIFO head is valid.
- `pix_x`, `pix_y`  out  COORD_W each: FIFO head coordinate.
- `pix_ready`  in  1: consumer takes the head this cycle.
- `busy`  out  1: state is not IDLE.
- `plot_done`  out  1: one-cycle pulse; all pixels of the line have been drained.
- `err`  out  1: sticky flag; an illegal direction code was accepted.

## Operation
- States:
  - IDLE: `step_ready` = 0.
  - RUN: steps are accepted.
  - DRAIN: `line_done` has been seen; the block is waiting for the FIFO to empty.
- `load` in any state:
  - flushes the FIFO;
  - sets the pen to (`start_x`, `start_y`);
  - enqueues that start pixel;
  - clears `err`;
  - moves to RUN.
  - `load` has priority over every other event in the same cycle.
- Step acceptance is `step_valid && step_ready`, with `step_ready` = (state == RUN) && (FIFO count < FIFO_DEPTH).
- For each accepted step:
  - Each axis moves by its code: +1, −1 or 0. An axis with code 11 does not move, and `err` is set.
  - Coordinate arithmetic is modulo 2^COORD_W: 255 + 1 → 0 and 0 − 1 → 255 when COORD_W = 8. No saturation.
  - If at least one axis moves, the new pen position is enqueued. If neither axis moves, nothing is enqueued.
- RUN → DRAIN when `line_done` is high. A step accepted in that same cycle is still applied and enqueued. `line_done` in IDLE or DRAIN is ignored.
- DRAIN → IDLE when the FIFO count is 0. `plot_done` pulses high for exactly the cycle in which the state becomes IDLE, and is then cleared.
- FIFO:
  - `pix_valid` = (count ≠ 0); the head is presented on `pix_x`/`pix_y`.
  - Pop on `pix_valid && pix_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - There is no push when full, because `step_ready` is already low.
  - Ordering is strict FIFO.

## Timing
- Reset values:
  - state IDLE, FIFO empty, pen (0,0);
  - `step_ready` 0, `pix_valid` 0, `pix_x`/`pix_y` 0;
  - `busy` 0, `plot_done` 0, `err` 0.
- `load` at edge N: `pix_valid` = 1 with the start pixel and `step_ready` = 1 after edge N.
- A step accepted at edge N is visible on `pix_*` after edge N if the FIFO was empty. Latency is one edge, with no bubble.
- Sustained throughput: one step per cycle while `pix_ready` is held high.
- `rst_n` deassertion is synchronised externally. Reset asserted mid-line discards FIFO contents immediately, without waiting for a clock.

## Test plan
- Reset then idle:
  - all outputs 0;
  - `step_valid` = 1 with code 01/01 for 5 cycles → nothing accepted, `pix_valid` stays 0.
- Load (30,30), then steps (10,10)×6 followed by (00,10)×3, then `line_done`, with `pix_ready` held 1:
  - pixels in order: (30,30), (29,29), …, (24,24), (24,23), (24,22), (24,21);
  - `plot_done` pulses once, one cycle after the last pop;
  - `busy` falls in that same cycle.
- Backpressure, FIFO_DEPTH = 4, `pix_ready` = 0, load (20,25) followed by continuous 01/01 steps:
  - `step_ready` drops after 3 accepted steps (count 4);
  - raising `pix_ready` then yields (20,25), (21,26), (22,27), (23,28), (24,29), … with no loss or duplication.
- Wrap and hold, load (255,0), steps (01,10) then (00,00):
  - enqueued pixels are (255,0) then (0,255) only;
  - the 00/00 step is accepted but produces no pixel.
- Illegal code and reload:
  - step (11,01) from (5,5) → pixel (5,6), `err` = 1;
  - `load` mid-RUN with (40,40) → FIFO flushed, `err` = 0, next head is (40,40).
- Async reset asserted mid-DRAIN with 3 entries queued → `pix_valid` and `busy` go to 0 before the next clock edge; no `plot_done` pulse.
